// File: rtl/mod_99_rx_byte_stage_pkg.sv
// Shared constants, state encodings and the head-byte classifier for the
// 802.3br receive byte stage.
package mod_99_rx_byte_stage_pkg;

  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD      = 8'hD5;
  localparam logic [7:0] SMD_V    = 8'h07;
  localparam logic [7:0] SMD_R    = 8'h19;
  localparam logic [7:0] SMD_S0   = 8'hE6;
  localparam logic [7:0] SMD_S1   = 8'h4C;
  localparam logic [7:0] SMD_S2   = 8'h7F;
  localparam logic [7:0] SMD_S3   = 8'hB3;
  localparam logic [7:0] SMD_C0   = 8'h61;
  localparam logic [7:0] SMD_C1   = 8'h52;
  localparam logic [7:0] SMD_C2   = 8'h9E;
  localparam logic [7:0] SMD_C3   = 8'h2A;
  localparam logic [2:0] FRAG_NONE = 3'b111;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ASSEMBLE  = 2'd2,
    DRAIN     = 2'd3
  } rx_state_e;

  typedef enum logic {
    PHASE_LO = 1'b0,
    PHASE_HI = 1'b1
  } nibble_phase_e;

  typedef struct packed {
    logic       pream;
    logic       s;
    logic       c;
    logic       e;
    logic       v;
    logic       r;
    logic       err;
    logic       frame_hit;
    logic [1:0] frame_cnt;
    logic [2:0] frag_cnt;
  } byte_decode_t;

  // Context-free: the same byte can be an SMD-S and a frag count at once.
  function automatic byte_decode_t decode_byte(input logic valid,
                                               input logic [7:0] data,
                                               input logic err_bit);
    byte_decode_t d;
    d = '0;
    d.frag_cnt = FRAG_NONE;
    if (valid) begin
      d.pream = (data == PREAMBLE);
      d.e     = (data == SFD);
      d.v     = (data == SMD_V);
      d.r     = (data == SMD_R);
      case (data)
        SMD_S0: begin d.s = 1'b1; d.frame_cnt = 2'd0; d.frag_cnt = 3'd0; end
        SMD_S1: begin d.s = 1'b1; d.frame_cnt = 2'd1; d.frag_cnt = 3'd1; end
        SMD_S2: begin d.s = 1'b1; d.frame_cnt = 2'd2; d.frag_cnt = 3'd2; end
        SMD_S3: begin d.s = 1'b1; d.frame_cnt = 2'd3; d.frag_cnt = 3'd3; end
        SMD_C0: begin d.c = 1'b1; d.frame_cnt = 2'd0; end
        SMD_C1: begin d.c = 1'b1; d.frame_cnt = 2'd1; end
        SMD_C2: begin d.c = 1'b1; d.frame_cnt = 2'd2; end
        SMD_C3: begin d.c = 1'b1; d.frame_cnt = 2'd3; end
        default: ;
      endcase
      d.frame_hit = d.s | d.c;
      d.err = err_bit | ~(d.pream | d.e | d.v | d.r | d.s | d.c);
    end
    return d;
  endfunction

endpackage

// File: rtl/mod_99_rx_byte_stage_if.sv
// MII receive side plus consumer-facing byte/decode bus of the receive byte stage.
interface mod_99_rx_byte_stage_if;
  logic       RX_DV;
  logic       RX_ER;
  logic [3:0] RXD;
  logic       rByteTake;
  logic       rRxDv;
  logic       rByteReady;
  logic [7:0] rRxData;
  logic       Pream;
  logic       S;
  logic       C;
  logic       E;
  logic       V;
  logic       R;
  logic       ERR;
  logic [1:0] rxFrameCnt;
  logic [2:0] rxFragCnt;
  logic       overrun;
  logic       odd_nibble;

  modport master (
    output RX_DV, RX_ER, RXD, rByteTake,
    input  rRxDv, rByteReady, rRxData, Pream, S, C, E, V, R, ERR,
           rxFrameCnt, rxFragCnt, overrun, odd_nibble
  );

  modport slave (
    input  RX_DV, RX_ER, RXD, rByteTake,
    output rRxDv, rByteReady, rRxData, Pream, S, C, E, V, R, ERR,
           rxFrameCnt, rxFragCnt, overrun, odd_nibble
  );
endinterface

// File: rtl/mod_99_rx_byte_fifo.sv
// Small byte FIFO; each entry is {err_bit, data[7:0]}. A push while full is
// only taken when a pop frees the head slot in the same clock.
module mod_99_rx_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       reset_begin,
  input  logic       push,
  input  logic [8:0] push_data,
  input  logic       pop,
  output logic [8:0] head,
  output logic       full,
  output logic       empty,
  output logic       one_left
);

  logic [8:0]       mem_q [DEPTH];
  logic [8:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the count MSB alone means full.
  assign full     = count_q[PTR_W];
  assign empty    = (count_q == '0);
  assign one_left = (count_q == {{PTR_W{1'b0}}, 1'b1});
  assign head     = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_begin) begin
    if (reset_begin) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mod_99_rx_byte_stage.sv
// MII nibble-to-byte assembler feeding a byte FIFO, with combinational
// classification of the head byte for the 802.3br receive FSM.
module mod_99_rx_byte_stage
  import mod_99_rx_byte_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input logic                    clk,
  input logic                    reset_begin,
  mod_99_rx_byte_stage_if.slave  rx
);

  rx_state_e     state_q, state_d;
  nibble_phase_e phase_q, phase_d;
  logic [3:0]    lo_nib_q, lo_nib_d;
  logic          lo_err_q, lo_err_d;
  logic          drop_flag_q, drop_flag_d;
  logic          rx_dv_q, rx_dv_d;
  logic          overrun_q, overrun_d;
  logic          odd_nibble_q, odd_nibble_d;
  logic [1:0]    frame_cnt_q, frame_cnt_d;

  logic          push_req;
  logic          pop_req;
  logic          push_err;
  logic          drop;
  logic [8:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_one_left;
  byte_decode_t  dec;

  mod_99_rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk         (clk),
    .reset_begin (reset_begin),
    .push        (push_req),
    .push_data   ({push_err, rx.RXD, lo_nib_q}),
    .pop         (rx.rByteTake),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .one_left    (fifo_one_left)
  );

  // A byte dropped on overrun taints the next byte that does get in.
  assign push_err = rx.RX_ER | lo_err_q | drop_flag_q;
  assign pop_req  = rx.rByteTake && !fifo_empty;
  assign drop     = push_req && fifo_full && !pop_req;
  assign dec      = decode_byte(!fifo_empty, fifo_head[7:0], fifo_head[8]);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    lo_nib_d     = lo_nib_q;
    lo_err_d     = lo_err_q;
    drop_flag_d  = drop_flag_q;
    rx_dv_d      = rx_dv_q;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = 1'b0;
    odd_nibble_d = 1'b0;
    push_req     = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        if (!rx.RX_DV) state_d = IDLE;
      end
      IDLE: begin
        if (rx.RX_DV) begin
          state_d  = ASSEMBLE;
          lo_nib_d = rx.RXD;
          lo_err_d = rx.RX_ER;
          phase_d  = PHASE_HI;
        end
      end
      ASSEMBLE: begin
        if (rx.RX_DV) begin
          if (phase_q == PHASE_LO) begin
            lo_nib_d = rx.RXD;
            lo_err_d = rx.RX_ER;
            phase_d  = PHASE_HI;
          end else begin
            push_req = 1'b1;
            phase_d  = PHASE_LO;
          end
        end else begin
          state_d      = DRAIN;
          phase_d      = PHASE_LO;
          odd_nibble_d = (phase_q == PHASE_HI);
        end
      end
      DRAIN: begin
        if (rx.RX_DV) begin
          state_d  = ASSEMBLE;
          lo_nib_d = rx.RXD;
          lo_err_d = rx.RX_ER;
          phase_d  = PHASE_HI;
        end else if (fifo_empty || (pop_req && fifo_one_left)) begin
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (drop) begin
      overrun_d   = 1'b1;
      drop_flag_d = 1'b1;
    end else if (push_req) begin
      drop_flag_d = 1'b0;
    end

    // Leaving DRAIN always drops rRxDv, giving a gap before the next frame.
    if (state_q == DRAIN && state_d != DRAIN) begin
      rx_dv_d = 1'b0;
    end else if (push_req) begin
      rx_dv_d = 1'b1;
    end

    if (dec.frame_hit) frame_cnt_d = dec.frame_cnt;
  end

  always_ff @(posedge clk or posedge reset_begin) begin
    if (reset_begin) begin
      state_q      <= WAIT_IDLE;
      phase_q      <= PHASE_LO;
      lo_nib_q     <= '0;
      lo_err_q     <= 1'b0;
      drop_flag_q  <= 1'b0;
      rx_dv_q      <= 1'b0;
      overrun_q    <= 1'b0;
      odd_nibble_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      lo_nib_q     <= lo_nib_d;
      lo_err_q     <= lo_err_d;
      drop_flag_q  <= drop_flag_d;
      rx_dv_q      <= rx_dv_d;
      overrun_q    <= overrun_d;
      odd_nibble_q <= odd_nibble_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign rx.rRxDv      = rx_dv_q;
  assign rx.rByteReady = !fifo_empty;
  assign rx.rRxData    = fifo_empty ? 8'h00 : fifo_head[7:0];
  assign rx.Pream      = dec.pream;
  assign rx.S          = dec.s;
  assign rx.C          = dec.c;
  assign rx.E          = dec.e;
  assign rx.V          = dec.v;
  assign rx.R          = dec.r;
  assign rx.ERR        = dec.err;
  assign rx.rxFrameCnt = dec.frame_hit ? dec.frame_cnt : frame_cnt_q;
  assign rx.rxFragCnt  = dec.frag_cnt;
  assign rx.overrun    = overrun_q;
  assign rx.odd_nibble = odd_nibble_q;

endmodule

// File: tb/tb_mod_99_rx_byte_stage.sv
// Directed bench for the receive byte stage; expected values are hand-derived.
module tb_mod_99_rx_byte_stage;

  logic clk = 1'b0;
  logic reset_begin;
  int   n_compared = 0;
  int   n_mismatched = 0;

  mod_99_rx_byte_stage_if bus ();

  mod_99_rx_byte_stage #(
    .FIFO_DEPTH (4),
    .PTR_W      (2)
  ) dut (
    .clk         (clk),
    .reset_begin (reset_begin),
    .rx          (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dv, input logic er,
                               input logic [3:0] nib, input logic take);
    bus.RX_DV     = dv;
    bus.RX_ER     = er;
    bus.RXD       = nib;
    bus.rByteTake = take;
    tick();
    bus.rByteTake = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic er_lo,
                          input logic er_hi, input logic take);
    applyStimulus(1'b1, er_lo, b[3:0], 1'b0);
    applyStimulus(1'b1, er_hi, b[7:4], take);
  endtask

  // flags order: {Pream,S,C,E,V,R,ERR}
  task automatic checkHead(input string tag, input logic [7:0] data,
                           input logic [6:0] flags, input logic [1:0] fc,
                           input logic [2:0] frag);
    checkOutput({tag, ".ready"}, 32'(bus.rByteReady), 32'd1);
    checkOutput({tag, ".data"}, 32'(bus.rRxData), 32'(data));
    checkOutput({tag, ".flags"},
                32'({bus.Pream, bus.S, bus.C, bus.E, bus.V, bus.R, bus.ERR}),
                32'(flags));
    checkOutput({tag, ".frame_cnt"}, 32'(bus.rxFrameCnt), 32'(fc));
    checkOutput({tag, ".frag_cnt"}, 32'(bus.rxFragCnt), 32'(frag));
  endtask

  task automatic checkEmpty(input string tag, input logic exp_rxdv);
    checkOutput({tag, ".ready"}, 32'(bus.rByteReady), 32'd0);
    checkOutput({tag, ".rRxDv"}, 32'(bus.rRxDv), 32'(exp_rxdv));
    checkOutput({tag, ".flags"},
                32'({bus.Pream, bus.S, bus.C, bus.E, bus.V, bus.R, bus.ERR}),
                32'd0);
    checkOutput({tag, ".frag_cnt"}, 32'(bus.rxFragCnt), 32'h7);
  endtask

  initial begin
    reset_begin   = 1'b1;
    bus.RX_DV     = 1'b1;
    bus.RX_ER     = 1'b0;
    bus.RXD       = 4'h5;
    bus.rByteTake = 1'b0;
    tick();
    tick();
    checkEmpty("reset", 1'b0);
    checkOutput("reset.data", 32'(bus.rRxData), 32'd0);
    checkOutput("reset.overrun", 32'(bus.overrun), 32'd0);
    checkOutput("reset.odd", 32'(bus.odd_nibble), 32'd0);
    checkOutput("reset.frame_cnt", 32'(bus.rxFrameCnt), 32'd0);
    reset_begin = 1'b0;

    // Released mid-frame: nibbles ignored until RX_DV drops.
    applyStimulus(1'b1, 1'b0, 4'h5, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h5, 1'b0);
    checkEmpty("wait_idle", 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    sendByte(8'h55, 1'b0, 1'b0, 1'b0);
    checkHead("first55", 8'h55, 7'b1000000, 2'd0, 3'h7);
    checkOutput("first55.rRxDv", 32'(bus.rRxDv), 32'd1);
    sendByte(8'hD5, 1'b0, 1'b0, 1'b0);
    checkHead("queued55", 8'h55, 7'b1000000, 2'd0, 3'h7);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkHead("sfd", 8'hD5, 7'b0001000, 2'd0, 3'h7);
    checkOutput("sfd.odd", 32'(bus.odd_nibble), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkEmpty("sfd_end", 1'b0);

    // Preemptable frame; take on every push keeps the newest byte at head.
    for (int i = 0; i < 7; i++) sendByte(8'h55, 1'b0, 1'b0, 1'b1);
    checkHead("pre_pream", 8'h55, 7'b1000000, 2'd0, 3'h7);
    sendByte(8'hE6, 1'b0, 1'b0, 1'b1);
    checkHead("smd_s0", 8'hE6, 7'b0100000, 2'd0, 3'd0);
    sendByte(8'h12, 1'b0, 1'b0, 1'b1);
    checkHead("payload", 8'h12, 7'b0000001, 2'd0, 3'h7);
    sendByte(8'h34, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("pre_drain.rRxDv", 32'(bus.rRxDv), 32'd1);
    checkHead("pre_drain", 8'h12, 7'b0000001, 2'd0, 3'h7);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkHead("pre_last", 8'h34, 7'b0000001, 2'd0, 3'h7);
    checkOutput("pre_last.rRxDv", 32'(bus.rRxDv), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkEmpty("pre_end", 1'b0);

    // Continuation frame; frame count must hold past the SMD.
    for (int i = 0; i < 7; i++) sendByte(8'h55, 1'b0, 1'b0, 1'b1);
    sendByte(8'h52, 1'b0, 1'b0, 1'b1);
    checkHead("smd_c1", 8'h52, 7'b0010000, 2'd1, 3'h7);
    sendByte(8'h4C, 1'b0, 1'b0, 1'b1);
    checkHead("frag1", 8'h4C, 7'b0100000, 2'd1, 3'd1);
    sendByte(8'h12, 1'b0, 1'b0, 1'b1);
    checkHead("cont_data", 8'h12, 7'b0000001, 2'd1, 3'h7);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkEmpty("cont_drain", 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkEmpty("cont_end", 1'b0);

    // Overrun with no takes, then push+pop while full.
    sendByte(8'h11, 1'b0, 1'b0, 1'b0);
    sendByte(8'h22, 1'b0, 1'b0, 1'b0);
    sendByte(8'h33, 1'b0, 1'b0, 1'b0);
    sendByte(8'h44, 1'b0, 1'b0, 1'b0);
    checkOutput("full.overrun", 32'(bus.overrun), 32'd0);
    sendByte(8'h55, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr.overrun", 32'(bus.overrun), 32'd1);
    checkHead("ovr", 8'h11, 7'b0000001, 2'd1, 3'h7);
    applyStimulus(1'b1, 1'b0, 4'h7, 1'b0);
    checkOutput("ovr_pulse.overrun", 32'(bus.overrun), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
    checkOutput("fullpp.overrun", 32'(bus.overrun), 32'd0);
    checkHead("fullpp", 8'h22, 7'b0000001, 2'd1, 3'h7);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkHead("ovr_b3", 8'h33, 7'b0000001, 2'd1, 3'h7);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkHead("ovr_b4", 8'h44, 7'b0000001, 2'd1, 3'h7);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkHead("ovr_b6", 8'h07, 7'b0000101, 2'd1, 3'h7);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkEmpty("ovr_end", 1'b0);

    // Corrupted and unknown bytes.
    sendByte(8'h55, 1'b0, 1'b1, 1'b1);
    checkHead("er_hi55", 8'h55, 7'b1000001, 2'd1, 3'h7);
    sendByte(8'h19, 1'b1, 1'b0, 1'b1);
    checkHead("er_lo19", 8'h19, 7'b0000011, 2'd1, 3'h7);
    sendByte(8'h3C, 1'b0, 1'b0, 1'b1);
    checkHead("bad3c", 8'h3C, 7'b0000001, 2'd1, 3'h7);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkEmpty("bad_end", 1'b0);

    // Odd nibble: five nibbles then RX_DV low.
    sendByte(8'h55, 1'b0, 1'b0, 1'b0);
    checkHead("odd_b1", 8'h55, 7'b1000000, 2'd1, 3'h7);
    sendByte(8'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h7, 1'b0);
    checkOutput("odd_pre.odd", 32'(bus.odd_nibble), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("odd.odd", 32'(bus.odd_nibble), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("odd_pulse.odd", 32'(bus.odd_nibble), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkHead("odd_b2", 8'h55, 7'b1000000, 2'd1, 3'h7);
    checkOutput("odd_b2.rRxDv", 32'(bus.rRxDv), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkEmpty("odd_end", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
